// File: rtl/alu_ctrl_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_seq_pkg
// Description : Shared encodings for the ALU control sequencer: opcodes,
//               datapath register addresses and sequencer states.
// Revision    : 1.0  initial release
// ============================================================================
package alu_ctrl_seq_pkg;

    // Instruction opcodes (instr_op)
    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LDA  = 3'b001,
        OP_LDB  = 3'b010,
        OP_ADD  = 3'b011,
        OP_SUB  = 3'b100,
        OP_OUT  = 3'b101,
        OP_ADDO = 3'b110,
        OP_ILL  = 3'b111
    } op_e;

    // Datapath register addresses (dp_reg_addr)
    localparam logic [1:0] c_reg_a    = 2'd0;
    localparam logic [1:0] c_reg_b    = 2'd1;
    localparam logic [1:0] c_reg_o    = 2'd2;
    localparam logic [1:0] c_reg_none = 2'd3;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_FLAG = 2'd2
    } state_e;

    // Ops that run through the ALU and therefore need a FLAG cycle to
    // capture the registered carry.
    function automatic logic is_arith(input op_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_decode
// Description : Purely combinational control decode for the ALU sequencer.
//               (state, latched op, latched imm) -> datapath controls + done.
// Ports       : enable       in   gate; 0 forces all controls idle
//               state        in   sequencer state
//               op           in   latched opcode
//               imm          in   latched immediate
//               dp_reg_addr  out  datapath write address (3 = no write)
//               dp_s_reg     out  1 = load dp_in, 0 = load ALU result
//               dp_s         out  ALU op, 0 = add, 1 = sub
//               dp_in        out  datapath data input
//               done         out  final cycle of the current instruction
// Revision    : 1.0  initial release
// ============================================================================
module alu_ctrl_decode
    import alu_ctrl_seq_pkg::*;
#(
    parameter int BIT_WIDTH = 1
) (
    input  logic                 enable,
    input  state_e               state,
    input  op_e                  op,
    input  logic [BIT_WIDTH-1:0] imm,
    output logic [1:0]           dp_reg_addr,
    output logic                 dp_s_reg,
    output logic                 dp_s,
    output logic [BIT_WIDTH-1:0] dp_in,
    output logic                 done
);

    always_comb begin
        dp_reg_addr = c_reg_none;
        dp_s_reg    = 1'b0;
        dp_s        = 1'b0;
        dp_in       = '0;
        done        = 1'b0;

        if (enable) begin
            case (state)
                ST_EXEC: begin
                    case (op)
                        OP_LDA: begin
                            dp_reg_addr = c_reg_a;
                            dp_s_reg    = 1'b1;
                            dp_in       = imm;
                            done        = 1'b1;
                        end
                        OP_LDB: begin
                            dp_reg_addr = c_reg_b;
                            dp_s_reg    = 1'b1;
                            dp_in       = imm;
                            done        = 1'b1;
                        end
                        OP_ADD, OP_SUB, OP_ADDO: begin
                            dp_reg_addr = c_reg_a;
                            dp_s        = (op == OP_SUB);
                        end
                        OP_OUT: begin
                            dp_reg_addr = c_reg_o;
                            done        = 1'b1;
                        end
                        // NOP and the illegal opcode finish without a write
                        default: begin
                            done = 1'b1;
                        end
                    endcase
                end
                ST_FLAG: begin
                    done = 1'b1;
                    // ADDO copies the freshly written A into O
                    if (op == OP_ADDO) begin
                        dp_reg_addr = c_reg_o;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_seq
// Description : Instruction sequencer for an ALU/register datapath. Accepts
//               one instruction per valid/ready handshake, expands it into a
//               1-2 cycle control sequence and latches the datapath carry.
// Ports       : clk, rst_n            clock, synchronous active-low reset
//               instr_valid/ready     instruction handshake
//               instr_op, instr_imm   opcode and immediate
//               dp_cout               registered carry from the datapath
//               dp_in, dp_reg_addr,
//               dp_s_reg, dp_s        datapath controls
//               carry_flag            last add/sub carry
//               done                  pulse in final cycle of an instruction
//               illegal               sticky illegal-opcode flag
// Revision    : 1.0  initial release
// ============================================================================
module alu_ctrl_seq
    import alu_ctrl_seq_pkg::*;
#(
    parameter int BIT_WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [2:0]           instr_op,
    input  logic [BIT_WIDTH-1:0] instr_imm,
    input  logic                 dp_cout,
    output logic [BIT_WIDTH-1:0] dp_in,
    output logic [1:0]           dp_reg_addr,
    output logic                 dp_s_reg,
    output logic                 dp_s,
    output logic                 carry_flag,
    output logic                 done,
    output logic                 illegal
);

    state_e               r_state;
    state_e               w_state_nxt;
    op_e                  r_op;
    logic [BIT_WIDTH-1:0] r_imm;
    logic                 r_carry;
    logic                 r_illegal;
    logic                 w_accept;

    // Ready is masked by rst_n so nothing is handshaked while reset is held
    assign instr_ready = rst_n && (r_state == ST_IDLE);
    assign w_accept    = instr_valid && instr_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = is_arith(r_op) ? ST_FLAG : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Instruction latches and status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op      <= OP_NOP;
            r_imm     <= '0;
            r_carry   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= op_e'(instr_op);
                r_imm <= instr_imm;
            end
            // dp_cout reflects the EXEC result only once FLAG is reached
            if (r_state == ST_FLAG) begin
                r_carry <= dp_cout;
            end
            if ((r_state == ST_EXEC) && (r_op == OP_ILL)) begin
                r_illegal <= 1'b1;
            end
        end
    end

    assign carry_flag = r_carry;
    assign illegal    = r_illegal;

    // Controls are Moore-decoded; rst_n forces them idle so a reset in the
    // middle of an instruction issues no further write.
    alu_ctrl_decode #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_decode (
        .enable      (rst_n),
        .state       (r_state),
        .op          (r_op),
        .imm         (r_imm),
        .dp_reg_addr (dp_reg_addr),
        .dp_s_reg    (dp_s_reg),
        .dp_s        (dp_s),
        .dp_in       (dp_in),
        .done        (done)
    );

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_ctrl_seq
// Description : Testbench for alu_ctrl_seq wired to a behavioural ALU/register
//               datapath (A, B, O registers plus registered carry).
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_ctrl_seq;

    localparam int W = 4;

    logic         clk         = 1'b0;
    logic         rst_n       = 1'b0;
    logic         instr_valid = 1'b0;
    logic [2:0]   instr_op    = 3'd0;
    logic [W-1:0] instr_imm   = '0;
    logic         instr_ready;
    logic         dp_cout;
    logic [W-1:0] dp_in;
    logic [1:0]   dp_reg_addr;
    logic         dp_s_reg;
    logic         dp_s;
    logic         carry_flag;
    logic         done;
    logic         illegal;

    always #5 clk = ~clk;

    alu_ctrl_seq #(
        .BIT_WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_imm   (instr_imm),
        .dp_cout     (dp_cout),
        .dp_in       (dp_in),
        .dp_reg_addr (dp_reg_addr),
        .dp_s_reg    (dp_s_reg),
        .dp_s        (dp_s),
        .carry_flag  (carry_flag),
        .done        (done),
        .illegal     (illegal)
    );

    // ---------------- behavioural datapath (alu_with_reg stand-in) ---------
    logic [W-1:0] dp_a = '0, dp_b = '0, dp_o = '0;
    logic         dp_c = 1'b0;
    logic [W:0]   alu;
    assign alu     = dp_s ? ({1'b0, dp_a} + {1'b0, ~dp_b} + 1'b1)
                          : ({1'b0, dp_a} + {1'b0, dp_b});
    assign dp_cout = dp_c;

    always @(posedge clk) begin
        dp_c <= alu[W];   // carry register tracks the ALU every cycle
        case (dp_reg_addr)
            2'd0: dp_a <= dp_s_reg ? dp_in : alu[W-1:0];
            2'd1: dp_b <= dp_s_reg ? dp_in : alu[W-1:0];
            2'd2: dp_o <= dp_a;
            default: ;
        endcase
    end

    // ---------------- scoreboard ---------------------------------------------
    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] o;
        logic         c;
        logic         ill;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   acc_cnt  = 0;
    logic done_d   = 1'b0;

    logic [W-1:0] ref_a = '0, ref_b = '0, ref_o = '0;
    logic         ref_c = 1'b0, ref_ill = 1'b0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        done_d <= done;
        if (done === 1'b1) done_cnt++;
        if (instr_valid && instr_ready) acc_cnt++;
    end

    // The write/flag edge is the one ending the done cycle; compare after it.
    always @(negedge clk) begin
        if (done_d) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_done", 8'd1, 8'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_reg_a",  {4'd0, dp_a}, {4'd0, e.a});
                chk("sb_reg_b",  {4'd0, dp_b}, {4'd0, e.b});
                chk("sb_reg_o",  {4'd0, dp_o}, {4'd0, e.o});
                chk("sb_carry",  {7'd0, carry_flag}, {7'd0, e.c});
                chk("sb_illegal", {7'd0, illegal}, {7'd0, e.ill});
            end
        end
    end

    // Reference effect of one instruction on the architectural state
    task automatic ref_apply(input logic [2:0] op, input logic [W-1:0] imm);
        int s;
        case (op)
            3'd1: ref_a = imm;
            3'd2: ref_b = imm;
            3'd3, 3'd6: begin
                s     = int'(ref_a) + int'(ref_b);
                ref_c = (s >= 16);
                ref_a = 4'(s % 16);
                if (op == 3'd6) ref_o = ref_a;
            end
            3'd4: begin
                ref_c = (ref_a >= ref_b);
                ref_a = 4'((int'(ref_a) - int'(ref_b) + 16) % 16);
            end
            3'd5: ref_o = ref_a;
            3'd7: ref_ill = 1'b1;
            default: ;
        endcase
    endtask

    function automatic logic [1:0] exec_addr(input logic [2:0] op);
        case (op)
            3'd1, 3'd3, 3'd4, 3'd6: return 2'd0;
            3'd2:                   return 2'd1;
            3'd5:                   return 2'd2;
            default:                return 2'd3;
        endcase
    endfunction

    // Drive one instruction, wait for accept, check the EXEC cycle.
    // Returns at the negedge inside EXEC. hold keeps valid asserted with
    // junk op/imm, which must be ignored while ready is low.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] imm, input bit hold);
        int  n;
        logic arith;
        arith = (op == 3'd3) || (op == 3'd4) || (op == 3'd6);
        @(negedge clk);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_imm   = imm;
        n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", {7'd0, instr_ready}, 8'd1);
        ref_apply(op, imm);
        sb_q.push_back('{a: ref_a, b: ref_b, o: ref_o, c: ref_c, ill: ref_ill});
        @(negedge clk);
        chk("exec_ready", {7'd0, instr_ready}, 8'd0);
        chk("exec_addr",  {6'd0, dp_reg_addr}, {6'd0, exec_addr(op)});
        chk("exec_done",  {7'd0, done}, {7'd0, ~arith});
        if (op == 3'd1 || op == 3'd2) begin
            chk("exec_dp_in", {4'd0, dp_in}, {4'd0, imm});
            chk("exec_s_reg", {7'd0, dp_s_reg}, 8'd1);
        end
        if (arith) chk("exec_s", {7'd0, dp_s}, {7'd0, (op == 3'd4)});
        if (hold) begin
            instr_op  = 3'b111;
            instr_imm = ~imm;
        end else begin
            instr_valid = 1'b0;
        end
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int d0, a0;
        // ---------------- reset ------------------------------------------
        repeat (3) @(negedge clk);
        chk("rst_ready", {7'd0, instr_ready}, 8'd0);
        chk("rst_addr",  {6'd0, dp_reg_addr}, 8'd3);
        chk("rst_done",  {7'd0, done}, 8'd0);
        chk("rst_carry", {7'd0, carry_flag}, 8'd0);
        chk("rst_illegal", {7'd0, illegal}, 8'd0);
        chk("rst_dp_in", {4'd0, dp_in}, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", {7'd0, instr_ready}, 8'd1);

        // ---------------- 1: LDA 5, LDB 3, ADD, OUT ----------------------
        d0 = done_cnt;
        issue(3'd1, 4'd5, 0);
        issue(3'd2, 4'd3, 0);
        issue(3'd3, 4'd0, 0);
        @(negedge clk);
        chk("add_flag_done", {7'd0, done}, 8'd1);
        chk("add_flag_addr", {6'd0, dp_reg_addr}, 8'd3);
        issue(3'd5, 4'd0, 0);
        settle();
        chk("t1_o",     {4'd0, dp_o}, 8'd8);
        chk("t1_carry", {7'd0, carry_flag}, 8'd0);
        chk("t1_dones", 8'(done_cnt - d0), 8'd4);

        // ---------------- 2: LDA C, LDB 6, ADDO --------------------------
        issue(3'd1, 4'hC, 0);
        issue(3'd2, 4'h6, 0);
        issue(3'd6, 4'd0, 0);
        @(negedge clk);
        chk("addo_flag_addr", {6'd0, dp_reg_addr}, 8'd2);
        chk("addo_flag_done", {7'd0, done}, 8'd1);
        settle();
        chk("t2_a",     {4'd0, dp_a}, 8'd2);
        chk("t2_o",     {4'd0, dp_o}, 8'd2);
        chk("t2_carry", {7'd0, carry_flag}, 8'd1);

        // ---------------- 3: six back-to-back ops, valid held high -------
        a0 = acc_cnt;
        issue(3'd1, 4'd9, 1);
        issue(3'd2, 4'd6, 1);
        issue(3'd3, 4'd0, 1);
        issue(3'd0, 4'd0, 1);
        issue(3'd5, 4'd0, 1);
        issue(3'd4, 4'd0, 0);
        settle();
        chk("t3_accepts", 8'(acc_cnt - a0), 8'd6);
        chk("t3_o", {4'd0, dp_o}, 8'd15);
        chk("t3_a", {4'd0, dp_a}, 8'd9);

        // ---------------- 4: LDA 7, LDB 3, SUB, OUT ----------------------
        issue(3'd1, 4'd7, 0);
        issue(3'd2, 4'd3, 0);
        issue(3'd4, 4'd0, 0);
        issue(3'd5, 4'd0, 0);
        settle();
        chk("t4_o", {4'd0, dp_o}, 8'd4);
        chk("t4_carry", {7'd0, carry_flag}, 8'd1);

        // ---------------- 5: illegal opcode ------------------------------
        issue(3'd7, 4'hF, 0);
        issue(3'd1, 4'd1, 0);
        issue(3'd5, 4'd0, 0);
        settle();
        chk("t5_illegal", {7'd0, illegal}, 8'd1);
        chk("t5_o", {4'd0, dp_o}, 8'd1);

        // ---------------- 6: reset during FLAG of ADD --------------------
        issue(3'd1, 4'd1, 0);
        issue(3'd2, 4'd2, 0);
        issue(3'd3, 4'd0, 0);
        @(negedge clk);          // FLAG
        rst_n = 1'b0;
        #1;
        chk("t6_rst_addr",  {6'd0, dp_reg_addr}, 8'd3);
        chk("t6_rst_ready", {7'd0, instr_ready}, 8'd0);
        chk("t6_rst_done",  {7'd0, done}, 8'd0);
        sb_q.delete();           // aborted ADD never completes
        ref_c   = 1'b0;
        ref_ill = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_carry",   {7'd0, carry_flag}, 8'd0);
        chk("t6_illegal", {7'd0, illegal}, 8'd0);
        chk("t6_o_kept",  {4'd0, dp_o}, 8'd1);
        issue(3'd5, 4'd0, 0);
        settle();
        chk("t6_o_after", {4'd0, dp_o}, 8'd3);

        chk("sb_drained", 8'(sb_q.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case a handshake never completes
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
